imem_loader: RTL and testbench

Program loader that writes the RV32I instruction memory. It accepts a byte stream over a valid/ready handshake from a host link such as a UART receiver or a bench driver. It assembles bytes little-endian into 32-bit instruction words and drives them into the IMEM write port at consecutive word addresses. It is the writer side of the IMEM, which the core's fetch path only reads.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host/IMEM signal bundle for the program loader
// The csum member exists only when IMEM_LOADER_CSUM_EN is defined.
interface imem_loader_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [LEN_W-1:0] len_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             err;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0]      csum;

  modport master (
    output start, len_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, csum
  );
  modport slave (
    input  start, len_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, csum
  );
`else
  modport master (
    output start, len_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
  modport slave (
    input  start, len_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to IMEM word writer (optional IMEM_LOADER_CSUM_EN checksum)
// Bytes are packed little-endian; each full word is written once at consecutive addresses.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 11
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] idx_inc;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  assign idx_inc = word_idx_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len_words > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            len_d      = bus.len_words;
            word_idx_d = '0;
            lane_d     = 2'd0;
            addr_d     = BASE_ADDR;
            err_d      = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d     = 32'd0;
`endif
            state_d    = (bus.len_words == '0) ? DONE : RECV;
          end
        end
      end
      RECV: begin
        if (bus.byte_valid) begin
          wdata_d[8*lane_q +: 8] = bus.byte_data;
          lane_d                 = lane_q + 2'd1;
          if (lane_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        word_idx_d = idx_inc;
        // Address tracks the index so it is registered and stable during the write cycle.
        addr_d     = BASE_ADDR + (32'(idx_inc) << 2);
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = csum_q + wdata_q;
`endif
        state_d    = (idx_inc == len_q) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      word_idx_q <= '0;
      len_q      <= '0;
      wdata_q    <= 32'd0;
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = (state_q == RECV);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.busy       = (state_q == RECV) || (state_q == WRITE);
  assign bus.done       = (state_q == DONE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.err        = err_q;
`ifdef IMEM_LOADER_CSUM_EN
  assign bus.csum       = csum_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_imem_loader;
  localparam int LEN_W = 11;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.LEN_W(LEN_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stream [0:7];
  logic [31:0] imem [0:15];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc [$];
  int          cyc_cnt  = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc_cnt);
      if (bus.mem_addr < 32'd64) imem[bus.mem_addr[5:2]] = bus.mem_wdata;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_cnt;
    end
  end

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    for (int i = 0; i < 16; i++) imem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] len);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.len_words = len;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.len_words = '0;
  endtask

  task automatic drive_bytes(input int n, input bit gapped, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.byte_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = stream[idx];
      bus.start      = poke_start && (cyc == 3);
      bus.len_words  = '0;
      if (bus.byte_valid && bus.byte_ready) idx++;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    if (idx != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: consumed %0d bytes, required %0d", idx, n);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt > 0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b required 0", bus.byte_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b required 0", bus.mem_we); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", bus.done); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", bus.err); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h required 00000000", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h required 00000000", bus.mem_wdata); end
`ifdef IMEM_LOADER_CSUM_EN
    n_checks++; if (bus.csum !== 32'h0) begin n_fail++; $display("FAIL rst_csum: got %h required 00000000", bus.csum); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_two_word(input bit gapped);
    bit seen;
    clear_logs();
    pulse_start(11'd2);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL load_busy(g=%0d): got %b required 1", gapped, bus.busy); end
    n_checks++; if (bus.byte_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready(g=%0d): got %b required 1", gapped, bus.byte_ready); end
    drive_bytes(8, gapped, gapped);
    wait_done(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL load_done_seen(g=%0d): got 0 required 1", gapped); end
    n_checks++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL load_nwrites(g=%0d): got %0d required 2", gapped, wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_checks++; if (wr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL load_addr0(g=%0d): got %h required 00000000", gapped, wr_addr[0]); end
      n_checks++; if (wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL load_data0(g=%0d): got %h required 00000013", gapped, wr_data[0]); end
      n_checks++; if (wr_addr[1] !== 32'h4) begin n_fail++; $display("FAIL load_addr1(g=%0d): got %h required 00000004", gapped, wr_addr[1]); end
      n_checks++; if (wr_data[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL load_data1(g=%0d): got %h required 00100093", gapped, wr_data[1]); end
      n_checks++; if (done_cyc !== wr_cyc[1] + 1) begin n_fail++; $display("FAIL load_done_timing(g=%0d): got cycle %0d required %0d", gapped, done_cyc, wr_cyc[1] + 1); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL load_done_count(g=%0d): got %0d required 1", gapped, done_cnt); end
    n_checks++; if (imem[0] !== 32'h0000_0013 || imem[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL load_imem(g=%0d): got %h %h required 00000013 00100093", gapped, imem[0], imem[1]); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_after(g=%0d): got %b required 0", gapped, bus.busy); end
`ifdef IMEM_LOADER_CSUM_EN
    n_checks++; if (bus.csum !== 32'h0010_00A6) begin n_fail++; $display("FAIL load_csum(g=%0d): got %h required 001000a6", gapped, bus.csum); end
`endif
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start(11'd0);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b required 0", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b required 0", bus.done); end
    repeat (5) @(negedge clk);
    n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL zero_nwrites: got %0d required 0", wr_addr.size()); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_oversize();
    bit seen;
    clear_logs();
    pulse_start(11'(DEPTH + 1));
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL over_err: got %b required 1", bus.err); end
    n_checks++; if (bus.busy !== 1'b0 || bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL over_idle: got busy %b ready %b required 0 0", bus.busy, bus.byte_ready); end
    repeat (6) @(negedge clk);
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL over_err_sticky: got %b required 1", bus.err); end
    n_checks++; if (wr_addr.size() !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL over_quiet: got %0d writes %0d dones required 0 0", wr_addr.size(), done_cnt); end
    stream[0] = 8'h78; stream[1] = 8'h56; stream[2] = 8'h34; stream[3] = 8'h12;
    pulse_start(11'd1);
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL over_err_clear: got %b required 0", bus.err); end
    drive_bytes(4, 1'b0, 1'b0);
    wait_done(seen);
    n_checks++; if (wr_addr.size() !== 1 || wr_data[0] !== 32'h1234_5678 || wr_addr[0] !== 32'h0) begin
      n_fail++; $display("FAIL over_reload: got %0d writes first %h@%h required 1 write 12345678@00000000", wr_addr.size(), wr_data[0], wr_addr[0]);
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL over_reload_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h00; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h00; stream[6] = 8'h10; stream[7] = 8'h00;
    pulse_start(11'd2);
    drive_bytes(6, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_state: got busy %b addr %h required 0 00000000", bus.busy, bus.mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    repeat (8) @(negedge clk);
    bus.byte_valid = 1'b0;
    n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL mid_nwrites: got %0d required 1", wr_addr.size()); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d required 0", done_cnt); end
    clear_logs();
    for (int i = 0; i < 4; i++) stream[i] = 8'hFF;
    pulse_start(11'd1);
    drive_bytes(4, 1'b0, 1'b0);
    wait_done(seen);
    n_checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mid_fresh: got %0d writes first %h@%h required 1 write ffffffff@00000000", wr_addr.size(), wr_data[0], wr_addr[0]);
    end
`ifdef IMEM_LOADER_CSUM_EN
    n_checks++; if (bus.csum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_csum: got %h required ffffffff", bus.csum); end
`endif
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.len_words  = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h00; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h00; stream[6] = 8'h10; stream[7] = 8'h00;
    test_reset();
    test_two_word(1'b0);
    test_two_word(1'b1);
    test_zero_len();
    test_oversize();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
